// File: rtl/ascii_scroller_pkg.sv
// Shared types and constants for the ASCII scroll sequencer.
package ascii_scroll_pkg;

    // Sequencer states.
    typedef enum logic {
        IDLE   = 1'b0,
        SCROLL = 1'b1
    } scroll_state_t;

    // Width of one display lane (one ASCII code).
    localparam int ASCII_W = 8;

    // Code shown on a lane that has no character to display.
    localparam logic [ASCII_W-1:0] ASCII_BLANK = 8'h20;

endpackage

// File: rtl/ascii_scroller_if.sv
// Character write port: producer appends characters, or empties the buffer.
interface ascii_scroller_if;
    import ascii_scroll_pkg::*;

    logic               wr_valid;
    logic [ASCII_W-1:0] wr_char;
    logic               wr_ready;
    logic               wr_clear;

    // Producer side.
    modport master (
        output wr_valid,
        output wr_char,
        output wr_clear,
        input  wr_ready
    );

    // Message buffer side.
    modport slave (
        input  wr_valid,
        input  wr_char,
        input  wr_clear,
        output wr_ready
    );

endinterface

// File: rtl/ascii_scroller_tick.sv
// Scroll step timer: one-cycle pulse after every TICK_DIV enabled cycles.
module scroll_tick #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt;

    // The pulse fires on the last cycle of a period, only while counting is enabled.
    assign tick = en && (cnt == CNT_W'(TICK_DIV - 1));

    // Count enabled cycles; a disabled cycle holds the count so a paused period resumes.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ascii_scroller.sv
// Message buffer and right-to-left scroll sequencer for a row of ASCII digit lanes.
module ascii_scroller
    import ascii_scroll_pkg::*;
#(
    parameter int MSG_DEPTH  = 32,
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 25_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    ascii_scroller_if.slave               wr,
    input  logic                          start,
    input  logic                          loop_en,
    input  logic                          pause,
    output logic [ASCII_W*NUM_DIGITS-1:0] digit_ascii,
    output logic                          busy,
    output logic                          done
);

    localparam int LEN_W  = $clog2(MSG_DEPTH + 1);
    localparam int POS_W  = $clog2(MSG_DEPTH + NUM_DIGITS);
    localparam int ADDR_W = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;

    scroll_state_t      state;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_next;
    logic [POS_W-1:0]   pos;
    logic [POS_W-1:0]   last_pos;
    logic [ASCII_W-1:0] msg_buf [MSG_DEPTH];
    logic               wr_fire;
    logic               tick;
    logic               tick_clr;
    logic               tick_en;
    logic signed [POS_W:0] lane_idx;

    // Writes are only taken while idle and the buffer has room; clear wins over a write.
    assign wr.wr_ready = (state == IDLE) && (len < LEN_W'(MSG_DEPTH));
    assign wr_fire     = wr.wr_valid && wr.wr_ready && !wr.wr_clear;
    assign busy        = (state == SCROLL);

    // Final position: the last character has scrolled past the leftmost lane.
    assign last_pos = POS_W'(len) + POS_W'(NUM_DIGITS - 1);

    // The timer restarts from zero on every entry to SCROLL and freezes while paused.
    assign tick_clr = (state == IDLE);
    assign tick_en  = (state == SCROLL) && !pause;

    scroll_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .en    (tick_en),
        .tick  (tick)
    );

    // Buffer length after this cycle's clear/write, so a same-cycle write can start a scroll.
    always_comb begin
        len_next = len;
        if (wr.wr_clear) begin
            len_next = '0;
        end else if (wr_fire) begin
            len_next = len + LEN_W'(1);
        end
    end

    // Append accepted characters to the buffer.
    // NOTE: the buffer carries no reset; len alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            msg_buf[ADDR_W'(len)] <= wr.wr_char;
        end
    end

    // Sequencer: buffer length, scroll position, and the completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            len   <= '0;
            pos   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    len <= len_next;
                    if (start && (len_next != '0)) begin
                        state <= SCROLL;
                        pos   <= '0;
                    end
                end
                SCROLL: begin
                    if (tick) begin
                        if (pos == last_pos) begin
                            pos <= '0;
                            if (!loop_en) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            pos <= pos + POS_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane k shows stream character pos-k; anything outside the message is blank.
    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        digit_ascii = {NUM_DIGITS{ASCII_BLANK}};
        lane_idx    = '0;
        if (state == SCROLL) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                lane_idx = $signed({1'b0, pos}) - $signed((POS_W + 1)'(k));
                if (!lane_idx[POS_W] && (lane_idx[POS_W-1:0] < POS_W'(len))) begin
                    digit_ascii[k*ASCII_W +: ASCII_W] = msg_buf[ADDR_W'(lane_idx[POS_W-1:0])];
                end
            end
        end
    end

endmodule

// File: doc/ascii_scroller.md
# ascii_scroller

Message buffer and scroll sequencer that produces ASCII codes for a row of seven-segment digits. A producer writes a character string through a valid/ready port. On `start`, the block scrolls the string right-to-left across `NUM_DIGITS` positions at a fixed tick rate. Each 8-bit output lane drives one ASCII-to-seven-segment decoder per HEX digit in the alarm-clock top level.

## Interface
- `MSG_DEPTH`, 32: buffer capacity in characters (power of 2 not required).
- `NUM_DIGITS`, 6: number of display lanes.
- `TICK_DIV`, 25_000_000: clocks per scroll step (≥2).
- `clk`  in  1: single clock domain.
- `reset`  in  1: synchronous, active-high.
- `wr_valid`  in  1: character write request.
- `wr_char`  in  8: ASCII character to append.
- `wr_ready`  out  1: write accepted when `wr_valid && wr_ready`.
- `wr_clear`  in  1: empty the buffer (length := 0); honoured only in IDLE.
- `start`  in  1: begin scrolling; level or pulse, sampled in IDLE.
- `loop_en`  in  1: repeat the message instead of finishing.
- `pause`  in  1: freeze the tick counter and position.
- `digit_ascii`  out  8*NUM_DIGITS: lane k = bits [8k+7:8k]; lane 0 = rightmost digit.
- `busy`  out  1: high in SCROLL.
- `done`  out  1: one-cycle pulse when a non-looping scroll completes.

## Operation
- States: IDLE, SCROLL.
- **IDLE**
  - `wr_ready = (len < MSG_DEPTH)`.
  - An accepted write stores `wr_char` at `buf[len]` and then increments `len`.
  - `wr_clear` sets `len` to 0. It has priority over a write in the same cycle, and that write is dropped.
  - `start && len_next > 0` moves to SCROLL with `pos := 0` and tick counter := 0. `len_next` includes any write accepted that cycle.
  - `start` with an empty buffer is ignored.
  - All lanes read 8'h20 (blank).
- **SCROLL**
  - `wr_ready = 0`; `wr_clear` is ignored.
  - Virtual stream: `v[j] = buf[j]` for `0 ≤ j < len`; otherwise `v[j]` is blank, including negative j.
  - Lane k shows `v[pos − k]`.
  - On each tick, `pos` increments while `pos < LAST`, where `LAST = len + NUM_DIGITS − 1`. At `pos = LAST` every lane is blank.
- **Tick at pos = LAST**
  - If `loop_en = 1` (sampled at that tick): `pos := 0` and the block stays in SCROLL.
  - Otherwise: go to IDLE, pulse `done`, and keep `buf` and `len` so the same message can be started again.
- `pause = 1` holds the tick counter and `pos`; lanes stay static.
- Width rules:
  - `pos` is `$clog2(MSG_DEPTH+NUM_DIGITS)` bits.
  - `len` is `$clog2(MSG_DEPTH+1)` bits.
  - The `pos − k` index is computed signed; out-of-range values yield blank.
- Reset, including mid-scroll, forces:
  - state IDLE; `len`, `pos` and tick counter = 0;
  - `wr_ready = 1`, `busy = 0`, `done = 0`;
  - all lanes 8'h20.
  - Buffer contents need not be reset.

## Timing
- Write: accepted in the cycle `wr_valid && wr_ready`; `len` is updated on the next edge.
- `wr_ready` falls the cycle after the write that fills the buffer.
- `start` sampled at edge T: `busy = 1` and `pos = 0` from T+1.
- First advance occurs at edge T+TICK_DIV; later advances follow every TICK_DIV unpaused cycles.
- `digit_ascii` is a combinational function of the registered `pos`, `len` and `buf`. It changes in the same cycle `pos` updates, with no extra latency.
- `done` is high for exactly the cycle after the final tick, together with `busy = 0`.
- `pause` asserted in the cycle a tick would fire suppresses that tick.

## Structure
- Package `ascii_scroll_pkg`:
  - state enum `scroll_state_t {IDLE, SCROLL}`;
  - `ASCII_BLANK = 8'h20`;
  - lane width constant `ASCII_W = 8`.
- Sub-module `scroll_tick`:
  - parameter `TICK_DIV`;
  - inputs `clk`, `reset`, `clr`, `en`;
  - output `tick`, a one-cycle pulse every TICK_DIV enabled cycles, cleared by `clr`.
- Buffer is an inferred register array; no RAM macro.

## Test plan
All scenarios use MSG_DEPTH=8, NUM_DIGITS=6, TICK_DIV=4.
- **Reset:** all lanes 8'h20, `wr_ready = 1`, `busy = 0`, `done = 0`.
- **Scroll "HI"** (8'h48, 8'h49), then `start`, `loop_en = 0`:
  - at pos=0, lane0 = 8'h48, others blank;
  - at pos=1, lane0 = 8'h49 and lane1 = 8'h48;
  - at pos=7, all lanes blank, then `done` pulses;
  - 8 ticks total, 32 cycles after `start`.
- **Fill and overflow:** write 9 chars; `wr_ready` drops after the 8th; the 9th is not stored; `len = 8`.
- **Loop and pause:** with `loop_en = 1`, `pos` wraps from LAST to 0 with no `done`. Holding `pause` for 10 cycles mid-scroll leaves `pos` and the lanes unchanged; the next tick comes 4 unpaused cycles after release, counted from the start of the interrupted period.
- **Simultaneous events:**
  - write 'A' with `start` on an empty buffer: scroll begins with `len = 1`;
  - `wr_clear` with a write in the same cycle: `len = 0`;
  - `start` on an empty buffer: remains IDLE.
- **Reset mid-scroll** at pos=3: next cycle IDLE, lanes blank, `len = 0`. A following `start` without new writes is ignored.
